div_iter: RTL
=============

# div_iter

Iterative 32-bit integer divider for the DIV/DIVU instructions. It sits in the execute stage, and its registered quotient and remainder flow through the MEM/WB pipeline register into the write-back stage as `div_q` and `div_r`, where they feed the LO and HI write muxes. It uses one restoring-division step per cycle, and a start/busy/done handshake lets the pipeline controller stall the front end while a divide is in flight.

## Interface
- `DATA_W`, default 32: operand and result width. Only 32 is supported; the iteration counter width is derived from it.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a divide; sampled only in IDLE.
- `flush`  input  1  abort any divide in flight; has priority over `start`.
- `is_signed`  input  1  1 = DIV (two's complement), 0 = DIVU.
- `dividend`  input  DATA_W  rs operand; captured on the accepting edge.
- `divisor`  input  DATA_W  rt operand; captured on the accepting edge.
- `div_q`  output  DATA_W  registered quotient; goes to LO.
- `div_r`  output  DATA_W  registered remainder; goes to HI.
- `busy`  output  1  a divide is in progress.
- `done`  output  1  one-cycle pulse; `div_q` and `div_r` are valid in this cycle.

## Operation
- **State machine:** IDLE, CALC, SIGN.
- **IDLE**
  - If `start`=1 and `flush`=0: capture the operand magnitudes. When `is_signed` is set, negate a negative operand; otherwise use the operand as-is.
  - Also capture `sign_q` = sign(dividend) XOR sign(divisor), and `sign_r` = sign(dividend). Both are 0 when unsigned.
  - Clear the 33-bit partial remainder and the count, then go to CALC.
- **CALC** (32 cycles, count 0..31)
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
  - Increment count. When count is 31, go to SIGN.
- **SIGN** (1 cycle)
  - `div_q` = `sign_q` ? −quo : quo.
  - `div_r` = `sign_r` ? −rem : rem.
  - Assert `done`, return to IDLE.
- **Semantics**
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - dividend = q·divisor + r always holds for a non-zero divisor.
- **Divide by zero:** no special path; the result is whatever the algorithm produces.
  - DIVU: q = 0xFFFFFFFF, r = dividend.
  - DIV: q = 0xFFFFFFFF for dividend ≥ 0, q = 0x00000001 for dividend < 0; r = dividend.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0. Magnitudes are computed in 33 bits, so no wrap error occurs.
- **`start` while busy:** ignored and not queued.
- **`flush`:** in CALC or SIGN, go to IDLE next edge with `busy`=0. `done` is not asserted, and `div_q`/`div_r` keep their previous values.
- **Output hold:** `div_q`/`div_r` change only on the SIGN edge and hold until the next completed divide.

## Timing
- **Reset values:** `div_q`=0, `div_r`=0, `busy`=0, `done`=0, state IDLE, count 0.
- **Reset mid-operation:** a reset during CALC or SIGN returns the block to these values on the next edge, with no `done`.
- **Busy window:** `start` accepted at edge E0 → `busy`=1 after E0 → CALC iterations on E1..E32 → SIGN on E33.
- **Completion:** after E33, `done`=1 for exactly one cycle, `busy`=0, and the results are valid. Latency from `start` to `done` is 33 cycles; `busy` stays high for 33 cycles.
- **Back-to-back divides:** `start` may be asserted in the cycle `done`=1 (state is IDLE). It is accepted, and `done` still drops after one cycle.
- **Combinational paths:** `busy` and `done` are registered. There is no combinational path from inputs to outputs.
- **Pipeline use:** the controller stalls ID/EX while `busy`=1, and the writer latches `div_q`/`div_r` into the pipeline register on `done`.

## Test plan
- **Unsigned divide:** DIVU 100 / 7 → `done` 33 cycles after `start`; q=14, r=2; `busy` high for exactly 33 cycles.
- **Signed divide:** DIV 0xFFFFFFF9 (−7) / 2 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Then DIV 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
- **Signed overflow and divide by zero:**
  - DIV 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
  - DIVU 0x12345678 / 0 → q=0xFFFFFFFF, r=0x12345678.
- **Flush abort:** complete 100 / 7, then start 50 / 5 and assert `flush` in CALC cycle 10 → `busy`=0 next cycle, no `done`, outputs still 14/2. A following 50 / 5 → q=10, r=0.
- **Start handling:** pulse `start` with 9 / 4 while busy → ignored; the first result is unchanged. Assert `start` in the `done` cycle → the second divide completes 33 cycles later.
- **Reset mid-operation:** assert `rst` in CALC cycle 20 → next cycle all outputs are 0, state IDLE, and no `done` follows. Random signed/unsigned operand sweep checked against a reference model.

Source files
------------

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, a sign-fix cycle,
// and a start/busy/done handshake so the pipeline controller can stall while it runs.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] div_q,
    output logic [DATA_W-1:0] div_r,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam int                REM_W    = DATA_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    // Two's complement negation at operand width.
    function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    // Unsigned magnitude widened by one bit so that -2^(W-1) needs no special case.
    function automatic logic [REM_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic neg);
        logic [REM_W-1:0] m;
        if (neg) begin
            m = {1'b0, twos_neg(v)};
        end else begin
            m = {1'b0, v};
        end
        return m;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [REM_W-1:0]   rem_r;
    logic [DATA_W-1:0]  quo_r;
    logic [REM_W-1:0]   dvs_r;
    logic               sign_q_r;
    logic               sign_r_r;
    logic [DATA_W-1:0]  div_q_r;
    logic [DATA_W-1:0]  div_r_r;
    logic               busy_r;
    logic               done_r;

    logic               load_s;
    logic               step_s;
    logic               finish_s;
    logic               dvd_neg_s;
    logic               dvs_neg_s;
    logic [REM_W:0]     shift_s;
    logic [REM_W:0]     dvs_ext_s;
    logic               fits_s;
    logic [REM_W-1:0]   rem_next_s;
    logic [DATA_W-1:0]  quo_next_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-state datapath strobes; flush beats start and completion.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !flush) begin
                    load_s       = 1'b1;
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (count_r == CNT_LAST) begin
                    step_s       = 1'b1;
                    state_next_s = SIGN;
                end else begin
                    step_s       = 1'b1;
                    state_next_s = CALC;
                end
            end
            SIGN: begin
                if (flush) begin
                    finish_s = 1'b0;
                end else begin
                    finish_s = 1'b1;
                end
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One restoring step: the shifted partial remainder is one bit wider than the stored one.
    always_comb begin
        dvd_neg_s  = is_signed & dividend[DATA_W-1];
        dvs_neg_s  = is_signed & divisor[DATA_W-1];
        shift_s    = {rem_r, quo_r[DATA_W-1]};
        dvs_ext_s  = {1'b0, dvs_r};
        fits_s     = (shift_s >= dvs_ext_s);
        if (fits_s) begin
            rem_next_s = REM_W'(shift_s - dvs_ext_s);
            quo_next_s = {quo_r[DATA_W-2:0], 1'b1};
        end else begin
            rem_next_s = shift_s[REM_W-1:0];
            quo_next_s = {quo_r[DATA_W-2:0], 1'b0};
        end
    end

    // Operand capture, iteration, and registered result/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            dvs_r    <= '0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            div_q_r  <= '0;
            div_r_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= finish_s;
            if (load_s) begin
                quo_r    <= magnitude(dividend, dvd_neg_s)[DATA_W-1:0];
                dvs_r    <= magnitude(divisor, dvs_neg_s);
                rem_r    <= '0;
                count_r  <= '0;
                sign_q_r <= dvd_neg_s ^ dvs_neg_s;
                sign_r_r <= dvd_neg_s;
            end else if (step_s) begin
                rem_r   <= rem_next_s;
                quo_r   <= quo_next_s;
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
            if (finish_s) begin
                div_q_r <= sign_q_r ? twos_neg(quo_r) : quo_r;
                div_r_r <= sign_r_r ? twos_neg(rem_r[DATA_W-1:0]) : rem_r[DATA_W-1:0];
            end else begin
                div_q_r <= div_q_r;
            end
        end
    end

    assign div_q = div_q_r;
    assign div_r = div_r_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
